// File: rtl/exp2_pkg.sv
// exp2_pkg: shared widths and state encoding for the exp2/log2 datapaths.
//
// Contents:
//   BIT_INT, BIT_FRAC, BIT_OUT  default exponent and result widths
//   ACC_W                       shifter accumulator width (BIT_OUT+BIT_FRAC)
//   MAX_OUT                     all-ones result, used as the saturated value
//   state_e                     FSM encoding {IDLE, SHIFT}
package exp2_pkg;

    localparam int BIT_INT  = 4;
    localparam int BIT_FRAC = 4;
    localparam int BIT_OUT  = 12;
    localparam int ACC_W    = BIT_OUT + BIT_FRAC;

    localparam logic [BIT_OUT-1:0] MAX_OUT = {BIT_OUT{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/exp2_seq.sv
// exp2_seq: serial Mitchell antilog, DatOut ~= 2^(i.f) = 2^i * (1 + f).
//
// The mantissa {1, f} is loaded into an accumulator and shifted left once
// per clock, i times. The integer part of the result is the upper BIT_OUT
// bits of the accumulator.
//
// Handshake: a request is accepted on any rising edge where Start=1 and
// Ready=1 (Ready is high only in IDLE); DatIn is sampled on that edge only.
// Valid pulses for one cycle when DatOut/Ovf are updated, i+1 clocks after
// acceptance. Valid and Ready are both high in that cycle, so a new request
// can be accepted back-to-back. Start while busy is ignored.
//
// Ports:
//   Clk          clock
//   Rst_n        asynchronous active-low reset
//   Start        request strobe
//   DatIn        exponent, [BIT_INT+BIT_FRAC-1:BIT_FRAC]=i, [BIT_FRAC-1:0]=f
//   Ready        high while idle
//   Valid        one-cycle completion pulse
//   DatOut       result, held until the next completion
//   Ovf          overflow flag, held with DatOut
//   o_dbg_state  current FSM state (0=IDLE, 1=SHIFT)
//
// Build option: define EXP2_SAT_EN to saturate DatOut to all ones and raise
// Ovf when i >= BIT_OUT. Without it the truncated accumulator slice is
// output and Ovf is tied low.
module exp2_seq #(
    parameter int BIT_INT  = exp2_pkg::BIT_INT,
    parameter int BIT_FRAC = exp2_pkg::BIT_FRAC,
    parameter int BIT_OUT  = exp2_pkg::BIT_OUT
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        Start,
    input  logic [BIT_INT+BIT_FRAC-1:0] DatIn,
    output logic                        Ready,
    output logic                        Valid,
    output logic [BIT_OUT-1:0]          DatOut,
    output logic                        Ovf,
    output logic [0:0]                  o_dbg_state
);
    import exp2_pkg::*;

    localparam int ACC_LW = BIT_OUT + BIT_FRAC;

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_SHIFT = SHIFT;

    logic [0:0]          r_state;
    logic [ACC_LW-1:0]   r_acc;
    logic [BIT_INT-1:0]  r_cnt;
    logic                r_valid;
    logic [BIT_OUT-1:0]  r_dat_out;

    logic [BIT_INT-1:0]  w_int;
    logic [BIT_FRAC-1:0] w_frac;
    logic [ACC_LW-1:0]   w_acc_init;
    logic [BIT_OUT-1:0]  w_result;

    assign w_int  = DatIn[BIT_INT+BIT_FRAC-1:BIT_FRAC];
    assign w_frac = DatIn[BIT_FRAC-1:0];

    // Implicit leading one sits just above the fraction bits.
    assign w_acc_init = {{(ACC_LW-BIT_FRAC-1){1'b0}}, 1'b1, w_frac};
    assign w_result   = r_acc[ACC_LW-1:BIT_FRAC];

`ifdef EXP2_SAT_EN
    localparam logic [BIT_OUT-1:0] SAT_VAL = {BIT_OUT{1'b1}};

    logic r_ovf_sticky;
    logic r_ovf;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_dat_out <= '0;
`ifdef EXP2_SAT_EN
            r_ovf_sticky <= 1'b0;
            r_ovf        <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_acc   <= w_acc_init;
                        r_cnt   <= w_int;
                        r_state <= S_SHIFT;
`ifdef EXP2_SAT_EN
                        r_ovf_sticky <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_acc <= {r_acc[ACC_LW-2:0], 1'b0};
                        r_cnt <= r_cnt - 1'b1;
`ifdef EXP2_SAT_EN
                        // A one leaving the MSB means the result exceeds BIT_OUT bits.
                        if (r_acc[ACC_LW-1]) begin
                            r_ovf_sticky <= 1'b1;
                        end
`endif
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
`ifdef EXP2_SAT_EN
                        r_dat_out <= r_ovf_sticky ? SAT_VAL : w_result;
                        r_ovf     <= r_ovf_sticky;
`else
                        r_dat_out <= w_result;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Ready       = (r_state == S_IDLE);
    assign Valid       = r_valid;
    assign DatOut      = r_dat_out;
    assign o_dbg_state = r_state;

`ifdef EXP2_SAT_EN
    assign Ovf = r_ovf;
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: doc/exp2_seq.md
Name: exp2_seq

Overview:
- Inverse of the log2 datapath: converts a fixed-point base-2 logarithm (integer.fraction) back to a linear unsigned integer, 2^(i.f).
- Uses a Mitchell-style antilog, 2^(i+f) ≈ 2^i·(1+f), computed by a serial shifter, one bit per clock.
- Start/Ready/Valid handshake lets it sit behind the log unit or any upstream producer, trading latency for area.

Parameters:
- BIT_INT, 4: width of the integer part of the exponent input.
- BIT_FRAC, 4: width of the fractional part of the exponent input.
- BIT_OUT, 12: width of the linear result; the maximum in-range exponent integer is BIT_OUT-1.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  request; accepted only when Ready=1.
- DatIn  in  BIT_INT+BIT_FRAC  exponent. Bits [BIT_INT+BIT_FRAC-1:BIT_FRAC] = i (integer); bits [BIT_FRAC-1:0] = f (fraction).
- Ready  out  1  high only in IDLE.
- Valid  out  1  one-cycle pulse when DatOut is updated.
- DatOut  out  BIT_OUT  result; holds its value until the next completion.
- Ovf  out  1  overflow flag; valid while Valid=1 and held with DatOut.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE, Ready=1, Valid=0, DatOut=0, Ovf=0.
  - Internal acc, cnt and ovf_sticky cleared.
- Datapath:
  - acc is BIT_OUT+BIT_FRAC bits wide; cnt is BIT_INT bits wide.
  - Result = acc[BIT_OUT+BIT_FRAC-1:BIT_FRAC], i.e. floor((2^BIT_FRAC+f)·2^i / 2^BIT_FRAC).
- FSM states: IDLE, SHIFT.
- IDLE:
  - Start=1 at an edge: acc <= {0, 1'b1, f}; cnt <= i; ovf_sticky <= 0; go to SHIFT.
  - DatIn is sampled only on this edge.
- SHIFT, cnt != 0:
  - acc <= acc<<1; cnt <= cnt-1.
  - If acc MSB=1 before the shift, set ovf_sticky.
- SHIFT, cnt == 0:
  - DatOut <= result (or the saturated value, see Optional Feature); Ovf updated; Valid <= 1 for one cycle; go to IDLE.
- Latency: accept edge to Valid high is i+1 clocks. Minimum of 1 clock at i=0.
- Throughput: one result every i+2 clocks.
- Back-to-back: Valid and Ready are both high in the first IDLE cycle, so a Start there is accepted on that edge.
- Start while busy (Ready=0): ignored, not queued; DatIn changes have no effect.
- Reset mid-operation: the operation is aborted, no Valid is produced, and all outputs return to reset values.
- Overflow: occurs when i ≥ BIT_OUT, i.e. when a 1 is shifted out of the acc MSB.
- Boundary: i=BIT_OUT-1 with f=max is the largest in-range value and has no overflow.

Optional Feature:
- Macro EXP2_SAT_EN.
- Defined:
  - On overflow, DatOut = all ones (4095) and Ovf=1.
  - Otherwise Ovf=0.
- Undefined:
  - The result wraps; the truncated acc slice is output (e.g. 0 for i=12, f=0).
  - Ovf is tied to 0.
  - The ovf_sticky logic is not synthesised.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package exp2_pkg holds:
  - BIT_INT, BIT_FRAC and BIT_OUT defaults, plus derived ACC_W = BIT_OUT+BIT_FRAC.
  - The state enum {IDLE, SHIFT}.
  - MAX_OUT = {BIT_OUT{1'b1}}.
- No sub-module: the shifter and FSM are small and stay in one module.
- The log2 unit and this block both import exp2_pkg widths, keeping the round-trip interface consistent.

Test Plan:
- Reset, then Start with DatIn=0x00 -> Ready drops, Valid is high 1 clock after accept, DatOut=1, Ovf=0.
- DatIn=0x30 (i=3, f=0) -> Valid 4 clocks after accept, DatOut=8. DatIn=0x38 (f=0.5) -> DatOut=12.
- DatIn=0xB0 -> DatOut=2048 after 12 clocks. DatIn=0xBF -> DatOut=3968, Ovf=0.
- DatIn=0xC0:
  - With EXP2_SAT_EN: DatOut=4095, Ovf=1.
  - Without: DatOut=0, Ovf=0.
  - Repeat with 0xF0 for the same response.
- Start held high with DatIn toggling during SHIFT -> only the first value is processed. Back-to-back: a second Start in the Valid cycle is accepted and yields the correct second result.
- Assert Rst_n=0 mid-SHIFT for a 0xA0 request -> Valid never pulses, DatOut=0, Ready=1. A new 0x20 request afterwards -> DatOut=4.
